// File: rtl/md_unit_if.sv
// Decoder-to-MDU interface: E-stage issue strobes and operands in, HI/LO, busy and stall out.
// The flush strobe exists only when MDU_FLUSH_EN is defined.
interface md_unit_if;
  // start/hilo_we are single-cycle strobes with no ready: md_unit takes them only while idle,
  // and the hazard logic must hold further MD instructions while stall is high.
  logic        start;
  logic        hilo_we;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        md_use_d;
`ifdef MDU_FLUSH_EN
  logic        flush;
`endif
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;
  logic        stall;
  logic        state_dbg;

`ifdef MDU_FLUSH_EN
  modport master (output start, hilo_we, md_op, rs_val, rt_val, md_use_d, flush,
                  input  hi_out, lo_out, busy, stall, state_dbg);
  modport slave  (input  start, hilo_we, md_op, rs_val, rt_val, md_use_d, flush,
                  output hi_out, lo_out, busy, stall, state_dbg);
`else
  modport master (output start, hilo_we, md_op, rs_val, rt_val, md_use_d,
                  input  hi_out, lo_out, busy, stall, state_dbg);
  modport slave  (input  start, hilo_we, md_op, rs_val, rt_val, md_use_d,
                  output hi_out, lo_out, busy, stall, state_dbg);
`endif
endinterface

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers and a fixed-latency busy sequencer.
// Optional MDU_FLUSH_EN adds a flush input that aborts an in-flight op without committing.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic     clk,
  input logic     reset,
  md_unit_if.slave md
);
  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

  logic        op_signed;
  logic [63:0] ext_a, ext_b, prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe, uq, ur, quo, rem;
  logic [31:0] res_hi, res_lo;

  // One 64x64 multiplier serves both mult and multu: the low 64 bits of the product of the
  // sign- or zero-extended operands are the exact 64-bit result in either case.
  always_comb begin
    op_signed = ~md.md_op[0];
    ext_a     = op_signed ? {{32{md.rs_val[31]}}, md.rs_val} : {32'b0, md.rs_val};
    ext_b     = op_signed ? {{32{md.rt_val[31]}}, md.rt_val} : {32'b0, md.rt_val};
    prod      = ext_a * ext_b;

    // Signed divide via magnitudes; this also yields 0x8000_0000 / -1 = 0x8000_0000 rem 0.
    a_neg  = op_signed & md.rs_val[31];
    b_neg  = op_signed & md.rt_val[31];
    a_mag  = a_neg ? (32'd0 - md.rs_val) : md.rs_val;
    b_mag  = b_neg ? (32'd0 - md.rt_val) : md.rt_val;
    b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    uq     = a_mag / b_safe;
    ur     = a_mag % b_safe;
    quo    = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
    rem    = a_neg ? (32'd0 - ur) : ur;

    if (!md.md_op[1]) begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end else if (md.rt_val == 32'd0) begin
      res_hi = md.rs_val;
      res_lo = 32'hFFFF_FFFF;
    end else begin
      res_hi = rem;
      res_lo = quo;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    case (state_q)
      IDLE: begin
        if (md.start) begin
          if (!md.md_op[2]) begin
            pend_hi_d = res_hi;
            pend_lo_d = res_lo;
            cnt_d     = md.md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            state_d   = RUN;
          end
        end else if (md.hilo_we) begin
          if (md.md_op == 3'b100) hi_d = md.rs_val;
          if (md.md_op == 3'b101) lo_d = md.rs_val;
        end
      end
      RUN: begin
        if (cnt_q <= CW'(1)) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef MDU_FLUSH_EN
    // Flush beats both a same-cycle start and a pending commit.
    if (md.flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      if (state_q == RUN) begin
        hi_d = hi_q;
        lo_d = lo_q;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  assign md.hi_out    = hi_q;
  assign md.lo_out    = lo_q;
  assign md.busy      = (state_q == RUN);
  assign md.stall     = md.md_use_d & (md.busy | md.start);
  assign md.state_dbg = state_q;
endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: expected {HI,LO} pushed when an op is issued, popped at completion.
// Flush scenario is compiled in only with MDU_FLUSH_EN.
module tb_md_unit;
  logic clk = 1'b0;
  logic reset;
  md_unit_if md();

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .md(md));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue a mult/div op with md_use_d held, watch the busy window, then score the result.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp_res, input int n,
                        input bit poke, input bit we_too);
    int cyc = 0;
    logic [63:0] res;
    @(posedge clk); #1;
    md.start = 1'b1; md.hilo_we = we_too; md.md_op = op;
    md.rs_val = a; md.rt_val = b; md.md_use_d = 1'b1;
    exp_q.push_back(exp_res);
    #4;
    check({tag, " stall_start"}, 64'(md.stall), 64'd1);
    check({tag, " busy_start"}, 64'(md.busy), 64'd0);
    @(posedge clk); #1;
    md.start = 1'b0; md.hilo_we = 1'b0; md.rs_val = 32'h5A5A_5A5A; md.rt_val = 32'd3;
    while (md.busy === 1'b1 && cyc < 100) begin
      md.start = poke && (cyc == 1);
      md.hilo_we = poke && (cyc == 2);
      md.md_op = (poke && cyc == 2) ? 3'b100 : 3'b000;
      #4;
      check({tag, " stall_busy"}, 64'(md.stall), 64'd1);
      check({tag, " hilo_hold"}, {md.hi_out, md.lo_out}, {hi_m, lo_m});
      cyc++;
      @(posedge clk); #1;
    end
    md.start = 1'b0; md.hilo_we = 1'b0;
    check({tag, " busy_cycles"}, 64'(cyc), 64'(n));
    #4;
    check({tag, " stall_drop"}, 64'(md.stall), 64'd0);
    res = exp_q.pop_front();
    check({tag, " result"}, {md.hi_out, md.lo_out}, res);
    hi_m = res[63:32]; lo_m = res[31:0];
    md.md_use_d = 1'b0;
  endtask

  // Single-cycle strobe expected to complete (or be ignored) with zero latency.
  task automatic strobe(input string tag, input logic st, input logic we,
                        input logic [2:0] op, input logic [31:0] a, input logic [63:0] exp_res);
    logic [63:0] res;
    @(posedge clk); #1;
    md.start = st; md.hilo_we = we; md.md_op = op; md.rs_val = a;
    exp_q.push_back(exp_res);
    @(posedge clk); #1;
    md.start = 1'b0; md.hilo_we = 1'b0;
    res = exp_q.pop_front();
    check({tag, " result"}, {md.hi_out, md.lo_out}, res);
    check({tag, " busy"}, 64'(md.busy), 64'd0);
    hi_m = res[63:32]; lo_m = res[31:0];
  endtask

  initial begin
    logic [31:0] ra, rb;
    int sa, sb;
    longint p;
    reset = 1'b1;
    md.start = 1'b0; md.hilo_we = 1'b0; md.md_op = 3'b000;
    md.rs_val = 32'd0; md.rt_val = 32'd0; md.md_use_d = 1'b0;
`ifdef MDU_FLUSH_EN
    md.flush = 1'b0;
`endif
    #12;
    check("reset hilo", {md.hi_out, md.lo_out}, 64'd0);
    check("reset busy", 64'(md.busy), 64'd0);
    #5 reset = 1'b0;

    strobe("mthi_aaaa", 1'b0, 1'b1, 3'b100, 32'h0000_AAAA, {32'h0000_AAAA, 32'd0});
    strobe("mtlo_5555", 1'b0, 1'b1, 3'b101, 32'h0000_5555, {32'h0000_AAAA, 32'h0000_5555});

    // Asynchronous reset in the middle of a divide: no commit may follow.
    @(posedge clk); #1;
    md.start = 1'b1; md.md_op = 3'b010; md.rs_val = 32'd100; md.rt_val = 32'd3;
    @(posedge clk); #1;
    md.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midreset hilo", {md.hi_out, md.lo_out}, 64'd0);
    check("midreset busy", 64'(md.busy), 64'd0);
    hi_m = 32'd0; lo_m = 32'd0;
    #2 reset = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("midreset no_commit", {md.hi_out, md.lo_out}, 64'd0);
    check("midreset busy_after", 64'(md.busy), 64'd0);

    run_op("mult_m3x7", 3'b000, 32'hFFFF_FFFD, 32'd7, {32'hFFFF_FFFF, 32'hFFFF_FFEB}, 5, 1'b1, 1'b0);
    run_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'd2, {32'h0000_0001, 32'hFFFF_FFFE}, 5, 1'b0, 1'b0);
    run_op("divu_100_7", 3'b011, 32'd100, 32'd7, {32'd2, 32'd14}, 10, 1'b1, 1'b0);
    run_op("div_m7_2", 3'b010, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 10, 1'b0, 1'b0);
    run_op("div_5_0", 3'b010, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 10, 1'b0, 1'b0);
    run_op("div_min_m1", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 10, 1'b0, 1'b0);
    run_op("divu_max_0", 3'b011, 32'hFFFF_FFFF, 32'd0, {32'hFFFF_FFFF, 32'hFFFF_FFFF}, 10, 1'b0, 1'b0);
    run_op("start_beats_we", 3'b000, 32'd2, 32'd3, {32'd0, 32'd6}, 5, 1'b0, 1'b1);

    strobe("mthi_1234", 1'b0, 1'b1, 3'b100, 32'h0000_1234, {32'h0000_1234, lo_m});
    strobe("start_op100", 1'b1, 1'b0, 3'b100, 32'h0000_0777, {hi_m, lo_m});
    strobe("we_op000", 1'b0, 1'b1, 3'b000, 32'h0000_0888, {hi_m, lo_m});
    strobe("start_op110", 1'b1, 1'b0, 3'b110, 32'h0000_0999, {hi_m, lo_m});
    strobe("we_op111", 1'b0, 1'b1, 3'b111, 32'h0000_0AAA, {hi_m, lo_m});

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      if (i % 2 == 0) begin
        rb = $urandom;
        sa = ra; sb = rb;
        p = longint'(sa) * longint'(sb);
        run_op("rand_mult", 3'b000, ra, rb, 64'(p), 5, 1'b0, 1'b0);
      end else begin
        rb = $urandom_range(1, 1000);
        run_op("rand_divu", 3'b011, ra, rb, {ra % rb, ra / rb}, 10, 1'b0, 1'b0);
      end
    end

`ifdef MDU_FLUSH_EN
    @(posedge clk); #1;
    md.start = 1'b1; md.md_op = 3'b001; md.rs_val = 32'd6; md.rt_val = 32'd7;
    @(posedge clk); #1;
    md.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 md.flush = 1'b1;
    @(posedge clk); #1;
    md.flush = 1'b0;
    check("flush busy", 64'(md.busy), 64'd0);
    check("flush hilo", {md.hi_out, md.lo_out}, {hi_m, lo_m});
    repeat (8) @(posedge clk);
    #1;
    check("flush no_commit", {md.hi_out, md.lo_out}, {hi_m, lo_m});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
